vga_sync_monitor: RTL

Receiving end of the VGA timing interface driven by `display_controller`. The block consumes `hSync`/`vSync`/`bright`/`rgb` in the system clock domain and recovers the pixel coordinate of every displayed pixel. It checks line, frame, sync-width and blanking timing against parameters and reports lock status and errors. It is instantiated beside `display_controller` in the top level for on-board self-check and serves as the scoreboard front end in simulation.

---
 rtl/vga_sync_monitor.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receives the hSync/vSync/bright/rgb stream from
// display_controller. It checks line, frame, sync-width and blanking timing,
// tracks lock status, and recovers the active-area coordinate of each pixel.
module vga_sync_monitor #(
  parameter int CLKS_PER_PIX = 4,
  parameter int SAMPLE_PHASE = 2,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_ACT_START  = 144,
  parameter int H_ACT_END    = 784,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_ACT_START  = 35,
  parameter int V_ACT_END    = 515,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        bright,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [11:0] pix_rgb,
  output logic        h_err,
  output logic        v_err,
  output logic        bright_err,
  output logic [15:0] frame_cnt
);

  localparam int PIX_SHIFT = $clog2(CLKS_PER_PIX);
  localparam int GOOD_W    = $clog2(LOCK_FRAMES + 1);

  localparam logic [11:0] LINE_CLKS  = 12'(H_TOTAL * CLKS_PER_PIX);
  localparam logic [11:0] HSYNC_CLKS = 12'(H_SYNC * CLKS_PER_PIX);
  localparam logic [11:0] PHASE_MASK = 12'(CLKS_PER_PIX - 1);
  localparam logic [11:0] PHASE      = 12'(SAMPLE_PHASE);
  localparam logic [11:0] H_ACT_LO   = 12'(H_ACT_START);
  localparam logic [11:0] H_ACT_HI   = 12'(H_ACT_END);
  localparam logic [9:0]  V_ACT_LO   = 10'(V_ACT_START);
  localparam logic [9:0]  V_ACT_HI   = 10'(V_ACT_END);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VSYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t            state;
  logic              hsD, vsD;
  logic              seenH, seenV;
  logic [11:0]       lineClk;
  logic [9:0]        vLine;
  logic [GOOD_W-1:0] good;
  logic              dirty;

  // Sync edges relative to the previous-cycle inputs (syncs are active-low).
  logic hFall, hRise, vFall, vRise;
  assign hFall = hsD & ~hSync;
  assign hRise = ~hsD & hSync;
  assign vFall = vsD & ~vSync;
  assign vRise = ~vsD & vSync;

  // Pixel position within the line and the per-pixel sample point.
  logic [11:0] hPos;
  logic        samplePt;
  logic        inActive;
  assign hPos     = lineClk >> PIX_SHIFT;
  assign samplePt = ((lineClk & PHASE_MASK) == PHASE) && !hFall;
  assign inActive = (hPos >= H_ACT_LO) && (hPos < H_ACT_HI) &&
                    (vLine >= V_ACT_LO) && (vLine < V_ACT_HI);

  // Timing checks; in the hFall/vFall cycle lineClk/vLine still hold the
  // length of the line/frame that just ended.
  logic hErrDet, vErrDet, brightErrDet, anyErr;
  assign hErrDet = (hFall && seenH && (lineClk != LINE_CLKS)) ||
                   (hRise && (lineClk != HSYNC_CLKS));
  assign vErrDet = (vFall && !hFall) ||
                   (vFall && seenV && (vLine != V_LAST)) ||
                   (vRise && !hFall) ||
                   (vRise && (vLine != VSYNC_LAST));
  assign brightErrDet = (state == LOCKED) && samplePt && (bright != inActive);
  assign anyErr = hErrDet | vErrDet | brightErrDet;

  // A pixel is only delivered if the same cycle does not also drop lock.
  logic sampleHit;
  assign sampleHit = (state == LOCKED) && samplePt && bright && !anyErr;

  logic [GOOD_W-1:0] goodNext;
  assign goodNext = good + 1'b1;

  // Edge history, line clock counter and line counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design updates from pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsD     <= 1'b1;
      vsD     <= 1'b1;
      seenH   <= 1'b0;
      seenV   <= 1'b0;
      lineClk <= '0;
      vLine   <= '0;
    end else begin
      hsD <= hSync;
      vsD <= vSync;
      if (hFall) seenH <= 1'b1;
      if (vFall) seenV <= 1'b1;
      if (hFall) begin
        lineClk <= 12'd1;
      end else if (lineClk != 12'hFFF) begin
        lineClk <= lineClk + 12'd1;
      end
      if (vFall) begin
        vLine <= '0;
      end else if (hFall) begin
        vLine <= vLine + 10'd1;
      end
    end
  end

  // Registered one-clock error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      bright_err <= 1'b0;
    end else begin
      h_err      <= hErrDet;
      v_err      <= vErrDet;
      bright_err <= brightErrDet;
    end
  end

  // Pixel capture: strobe plus coordinate/colour that hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      pix_rgb   <= '0;
    end else begin
      pix_valid <= sampleHit;
      if (sampleHit) begin
        x       <= 10'(hPos - H_ACT_LO);
        y       <= vLine - V_ACT_LO;
        pix_rgb <= rgb;
      end
    end
  end

  // Lock FSM: acquire LOCK_FRAMES clean frames, drop on any error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNLOCKED;
      good      <= '0;
      dirty     <= 1'b0;
      locked    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (vFall) begin
            state <= ACQUIRE;
            good  <= '0;
            dirty <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (vFall) begin
            dirty <= 1'b0;
            if (dirty || anyErr) begin
              good <= '0;
            end else if (goodNext == LOCK_GOOD) begin
              state  <= LOCKED;
              locked <= 1'b1;
              good   <= '0;
            end else begin
              good <= goodNext;
            end
          end else if (anyErr) begin
            dirty <= 1'b1;
          end
        end
        LOCKED: begin
          if (anyErr) begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end else if (vFall) begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
